// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
package mouse_pkg;

  // Display geometry the cursor is confined to.
  localparam int unsigned H_VISIBLE = 1024;
  localparam int unsigned V_VISIBLE = 768;

  localparam int unsigned X_MAX_DEF  = H_VISIBLE - 1;
  localparam int unsigned Y_MAX_DEF  = V_VISIBLE - 1;
  localparam int unsigned X_INIT_DEF = H_VISIBLE / 2;
  localparam int unsigned Y_INIT_DEF = V_VISIBLE / 2;

  localparam int unsigned DELTA_W = 9;
  localparam int unsigned ACC_W   = 13;
  localparam int unsigned POS_W   = 12;

  // Byte0 bit positions.
  localparam int unsigned B0_LEFT   = 0;
  localparam int unsigned B0_RIGHT  = 1;
  localparam int unsigned B0_MIDDLE = 2;
  localparam int unsigned B0_SYNC   = 3;
  localparam int unsigned B0_XSIGN  = 4;
  localparam int unsigned B0_YSIGN  = 5;
  localparam int unsigned B0_XOVF   = 6;
  localparam int unsigned B0_YOVF   = 7;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  // Header fields kept from byte0 while the rest of the packet arrives.
  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic [2:0] btn;     // {middle, right, left}
  } hdr_t;

  function automatic hdr_t hdr_decode(input logic [7:0] b);
    hdr_t h;
    h.y_ovf  = b[B0_YOVF];
    h.x_ovf  = b[B0_XOVF];
    h.y_sign = b[B0_YSIGN];
    h.x_sign = b[B0_XSIGN];
    h.btn    = {b[B0_MIDDLE], b[B0_RIGHT], b[B0_LEFT]};
    return h;
  endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// One cursor axis: saturate the delta, accumulate and clamp to 0..MAX.
module mouse_axis_accum
  import mouse_pkg::*;
#(
  parameter int unsigned MAX  = 1023,
  parameter int unsigned INIT = 512,
  parameter bit          SUB  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DELTA_W-1:0]  delta,
  input  logic                ovf,
  input  logic                commit,
  output logic [POS_W-1:0]    pos
);

  logic [POS_W-1:0]   pos_q, pos_d;
  logic [DELTA_W-1:0] sat_c;
  logic [ACC_W-1:0]   ext_c, sum_c;

  // Saturate on overflow, add/subtract in 13-bit signed space, clamp.
  always_comb begin
    sat_c = delta;
    if (ovf) begin
      sat_c = delta[DELTA_W-1] ? DELTA_W'(9'h100) : DELTA_W'(9'h0FF);
    end
    ext_c = {{(ACC_W-DELTA_W){sat_c[DELTA_W-1]}}, sat_c};
    if (SUB) begin
      sum_c = ACC_W'({1'b0, pos_q}) - ext_c;
    end else begin
      sum_c = ACC_W'({1'b0, pos_q}) + ext_c;
    end
    pos_d = pos_q;
    if (commit) begin
      if (sum_c[ACC_W-1]) begin
        pos_d = '0;
      end else if (sum_c[POS_W-1:0] > POS_W'(MAX)) begin
        pos_d = POS_W'(MAX);
      end else begin
        pos_d = sum_c[POS_W-1:0];
      end
    end
  end

  // Position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos_q <= POS_W'(INIT);
    else        pos_q <= pos_d;
  end

  assign pos = pos_q;

endmodule

// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets into clamped cursor position and buttons.
module mouse_packet_decoder
  import mouse_pkg::*;
#(
  parameter int unsigned X_MAX          = X_MAX_DEF,
  parameter int unsigned Y_MAX          = Y_MAX_DEF,
  parameter int unsigned X_INIT         = X_INIT_DEF,
  parameter int unsigned Y_INIT         = Y_INIT_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left_mouse,
  output logic        right_mouse,
  output logic        middle_mouse,
  output logic        pkt_valid,
  output logic        sync_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hdr_t             hdr_q, hdr_d;
  logic [7:0]       dx_q, dx_d;
  logic [2:0]       btn_q, btn_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             commit_c;
  logic             tmo_c;

  // Next-state, timeout and packet capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    dx_d        = dx_q;
    btn_d       = btn_q;
    pkt_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    commit_c    = 1'b0;
    tmo_c       = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    case (state_q)
      WAIT_B0: begin
        cnt_d = '0;
        if (rx_valid) begin
          if (rx_data[B0_SYNC]) begin
            hdr_d   = hdr_decode(rx_data);
            state_d = WAIT_B1;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      WAIT_B1, WAIT_B2: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (state_q == WAIT_B1) begin
            dx_d    = rx_data;
            state_d = WAIT_B2;
          end else begin
            commit_c    = 1'b1;
            pkt_valid_d = 1'b1;
            btn_d       = hdr_q.btn;
            state_d     = WAIT_B0;
          end
        end else if (tmo_c) begin
          cnt_d      = '0;
          sync_err_d = 1'b1;
          state_d    = WAIT_B0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = WAIT_B0;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and packet registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_B0;
      cnt_q       <= '0;
      hdr_q       <= '0;
      dx_q        <= '0;
      btn_q       <= '0;
      pkt_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      dx_q        <= dx_d;
      btn_q       <= btn_d;
      pkt_valid_q <= pkt_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  mouse_axis_accum #(.MAX(X_MAX), .INIT(X_INIT), .SUB(1'b0)) u_x_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .delta  ({hdr_q.x_sign, dx_q}),
    .ovf    (hdr_q.x_ovf),
    .commit (commit_c),
    .pos    (xpos)
  );

  // Positive PS/2 dy means up, and y grows downward on screen.
  mouse_axis_accum #(.MAX(Y_MAX), .INIT(Y_INIT), .SUB(1'b1)) u_y_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .delta  ({hdr_q.y_sign, rx_data}),
    .ovf    (hdr_q.y_ovf),
    .commit (commit_c),
    .pos    (ypos)
  );

  assign left_mouse   = btn_q[0];
  assign right_mouse  = btn_q[1];
  assign middle_mouse = btn_q[2];
  assign pkt_valid    = pkt_valid_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Scoreboard bench: packet-level reference model feeds an expectation queue.
module tb_mouse_packet_decoder;

  localparam int T     = 8;
  localparam int XMAX  = 1023;
  localparam int YMAX  = 767;
  localparam int XINIT = 512;
  localparam int YINIT = 384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] xpos, ypos;
  logic        left_mouse, right_mouse, middle_mouse, pkt_valid, sync_err;

  always #5 clk = ~clk;

  mouse_packet_decoder #(
    .X_MAX(XMAX), .Y_MAX(YMAX), .X_INIT(XINIT), .Y_INIT(YINIT), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .xpos         (xpos),
    .ypos         (ypos),
    .left_mouse   (left_mouse),
    .right_mouse  (right_mouse),
    .middle_mouse (middle_mouse),
    .pkt_valid    (pkt_valid),
    .sync_err     (sync_err)
  );

  typedef struct {
    bit       is_err;
    int       x;
    int       y;
    bit [2:0] btn;
  } exp_t;

  exp_t     exp_q[$];
  int       vectors = 0;
  int       miscompares = 0;

  // Reference model state: cursor, bytes of the packet so far, idle cycles.
  int       mx, my;
  bit [7:0] part[$];
  int       idle;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int axis_delta(input bit s, input bit o, input bit [7:0] b);
    if (o) return s ? -256 : 255;
    return s ? int'(b) - 256 : int'(b);
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.x = mx; e.y = my; e.btn = 3'b000;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit v, input bit [7:0] d);
    exp_t     e;
    bit [7:0] b0;
    if (v) begin
      idle = 0;
      if (part.size() == 0 && !d[3]) begin
        push_err();
      end else begin
        part.push_back(d);
        if (part.size() == 3) begin
          b0 = part[0];
          mx = clamp(mx + axis_delta(b0[4], b0[6], part[1]), XMAX);
          my = clamp(my - axis_delta(b0[5], b0[7], part[2]), YMAX);
          e.is_err = 1'b0; e.x = mx; e.y = my; e.btn = b0[2:0];
          exp_q.push_back(e);
          part.delete();
        end
      end
    end else if (part.size() != 0) begin
      idle++;
      if (idle == T) begin
        push_err();
        part.delete();
        idle = 0;
      end
    end
  endtask

  // One clock of stimulus; the DUT samples it on the next rising edge.
  task automatic cyc(input bit v, input bit [7:0] d);
    rx_valid = v;
    rx_data  = d;
    model_step(v, d);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input bit [7:0] a, input bit [7:0] b, input bit [7:0] c);
    cyc(1'b1, a); cyc(1'b1, b); cyc(1'b1, c);
  endtask

  // Monitor: every output event pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (pkt_valid || sync_err)) begin
      if (pkt_valid && sync_err) check("pkt_err_exclusive", 1, 0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: pkt_valid=%0d sync_err=%0d with nothing expected at %0t",
                 pkt_valid, sync_err, $time);
      end else begin
        e = exp_q.pop_front();
        check("event_is_sync_err", int'(sync_err), int'(e.is_err));
        if (!e.is_err) begin
          check("xpos", int'(xpos), e.x);
          check("ypos", int'(ypos), e.y);
          check("buttons", int'({middle_mouse, right_mouse, left_mouse}), int'(e.btn));
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_xpos"}, int'(xpos), mx);
    check({tag, "_ypos"}, int'(ypos), my);
    check({tag, "_pkt_valid"}, int'(pkt_valid), 0);
    check({tag, "_sync_err"}, int'(sync_err), 0);
  endtask

  initial begin
    int gap;
    bit [7:0] b;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    mx = XINIT; my = YINIT; idle = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_buttons", int'({middle_mouse, right_mouse, left_mouse}), 0);
    @(posedge clk); #1;

    // Basic packet, then walk x down to 10 and clamp low.
    send_pkt(8'h09, 8'h10, 8'h05);
    cyc(1'b0, 8'h00);
    send_pkt(8'h58, 8'h00, 8'h00);
    send_pkt(8'h58, 8'h00, 8'h00);
    send_pkt(8'h58, 8'h00, 8'h00);
    send_pkt(8'h08, 8'h0A, 8'h00);
    send_pkt(8'h18, 8'hF0, 8'h00);
    // Walk y to 760, then overflow clamps high.
    send_pkt(8'h28, 8'h00, 8'h00);
    send_pkt(8'h28, 8'h00, 8'h83);
    send_pkt(8'h68, 8'h00, 8'h00);
    // Stray byte, then a packet with right and middle held.
    cyc(1'b1, 8'h00);
    send_pkt(8'h0E, 8'h01, 8'h01);
    // Timeout after byte1; stale dx must not be used.
    cyc(1'b1, 8'h08); cyc(1'b1, 8'h05);
    repeat (T + 2) cyc(1'b0, 8'h00);
    check_idle_outputs("after_timeout");
    send_pkt(8'h08, 8'h02, 8'h00);
    repeat (3) cyc(1'b0, 8'h00);

    // Reset between byte1 and byte2.
    cyc(1'b1, 8'h08); cyc(1'b1, 8'h05);
    rst_n = 1'b0;
    part.delete(); idle = 0; mx = XINIT; my = YINIT;
    #1;
    check_idle_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");
    @(posedge clk); #1;
    cyc(1'b1, 8'h00);
    repeat (2) cyc(1'b0, 8'h00);

    // Randomized stream with gaps, stray headers and occasional timeouts.
    for (int p = 0; p < 400; p++) begin
      for (int i = 0; i < 3; i++) begin
        gap = ($urandom_range(0, 99) < 4) ? int'($urandom_range(T - 2, T + 2))
                                          : int'($urandom_range(0, 2));
        repeat (gap) cyc(1'b0, 8'h00);
        b = 8'($urandom);
        if (i == 0) b[3] = ($urandom_range(0, 9) != 0);
        cyc(1'b1, b);
      end
    end

    repeat (T + 4) cyc(1'b0, 8'h00);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
